// File: rtl/md_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_seq_pkg
// Description : Shared definitions for the E-stage multiply/divide sequencer:
//               md opcode encoding, sequencer state encoding, default
//               latencies and small opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package md_seq_pkg;

    // md opcode encoding carried down the pipeline; 7..15 behave as NONE
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    typedef enum logic [0:0] {
        MDS_IDLE = 1'b0,
        MDS_RUN  = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a multi-cycle sequence
    function automatic logic md_is_seq(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Any real md op (sequenced or a direct HI/LO write)
    function automatic logic md_is_op(input logic [3:0] op);
        return (op != MD_NONE) && (op <= MD_MTLO);
    endfunction

endpackage : md_seq_pkg
`default_nettype wire

// File: rtl/md_seq_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_seq_arith
// Description : Purely combinational multiply/divide datapath.
//               MULT/MULTU : {o_res_hi, o_res_lo} = 64-bit product
//               DIV/DIVU   : o_res_lo = quotient (toward zero),
//                            o_res_hi = remainder (sign of dividend)
// Ports       : i_op [3:0]      md opcode
//               i_dh [31:0]     rs operand (dividend / multiplicand)
//               i_dl [31:0]     rt operand (divisor / multiplier)
//               o_res_hi [31:0] HI result
//               o_res_lo [31:0] LO result
//               o_div_zero      divide op with zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module md_seq_arith
    import md_seq_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_dh,
    input  logic [31:0] i_dl,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_sdiv;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_smul = $signed({{32{i_dh[31]}}, i_dh}) * $signed({{32{i_dl[31]}}, i_dl});
    assign w_umul = {32'd0, i_dh} * {32'd0, i_dl};

    // One unsigned divider serves both divides: signed operands are reduced
    // to magnitudes and signs re-applied afterwards. The magnitude of
    // 0x80000000 is representable unsigned, so the overflow case
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign w_sdiv   = (i_op == MD_DIV);
    assign w_a_neg  = w_sdiv & i_dh[31];
    assign w_b_neg  = w_sdiv & i_dl[31];
    assign w_a_mag  = w_a_neg ? (~i_dh + 32'd1) : i_dh;
    assign w_b_mag  = w_b_neg ? (~i_dl + 32'd1) : i_dl;
    // Result is discarded on a zero divisor; avoid dividing by zero anyway
    assign w_b_safe = (i_dl == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    assign o_div_zero = md_is_div(i_op) & (i_dl == 32'd0);

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        case (i_op)
            MD_MULT: begin
                o_res_hi = w_smul[63:32];
                o_res_lo = w_smul[31:0];
            end
            MD_MULTU: begin
                o_res_hi = w_umul[63:32];
                o_res_lo = w_umul[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_res_hi = w_r;
                o_res_lo = w_q;
            end
            default: begin
                o_res_hi = 32'd0;
                o_res_lo = 32'd0;
            end
        endcase
    end

endmodule : md_seq_arith
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// ============================================================================
// Module      : md_seq
// Description : E-stage multiply/divide sequencer. Captures the result of a
//               mult/div at start, holds the unit busy for a fixed latency,
//               then commits to the architectural HI/LO registers. Drives
//               busy/stall for hazard control so dependent D-stage md ops
//               and mfhi/mflo wait.
// Ports       : clk, rst        clock, synchronous active-high reset
//               op [3:0]        E-stage md opcode
//               valid           E-stage instruction is real
//               dh, dl [31:0]   rs / rt operands
//               d_uses_md       D-stage instruction touches the md unit
//               busy            sequence in progress (registered)
//               stall           freeze PC/D, bubble E (combinational)
//               done            one-cycle pulse on HI/LO commit
//               op_dropped      one-cycle pulse when an op is ignored
//               hi, lo [31:0]   architectural HI/LO
// Revision    : 1.0 - initial release
// ============================================================================
module md_seq
    import md_seq_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic        valid,
    input  logic [31:0] dh,
    input  logic [31:0] dl,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        op_dropped,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter is loaded with N-1 so that busy stays high exactly N cycles
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_nc;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_drop;

    logic        w_start;
    logic        w_finish;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_drop;
    logic [3:0]  w_cnt_load;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_zero;

    md_seq_arith u_arith (
        .i_op       (op),
        .i_dh       (dh),
        .i_dl       (dl),
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_drop      = 1'b0;
        w_cnt_load  = md_is_div(op) ? DIV_LOAD : MULT_LOAD;
        case (r_state)
            MDS_IDLE: begin
                w_start = valid & md_is_seq(op);
                w_mthi  = valid & (op == MD_MTHI);
                w_mtlo  = valid & (op == MD_MTLO);
                if (w_start) begin
                    w_state_nxt = MDS_RUN;
                end
            end
            MDS_RUN: begin
                w_drop   = valid & md_is_op(op);
                w_finish = (r_cnt == 4'd0);
                if (w_finish) begin
                    w_state_nxt = MDS_IDLE;
                end
            end
            default: begin
                w_state_nxt = MDS_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_nc   <= 1'b0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_drop <= w_drop;
            if (w_start) begin
                r_phi  <= w_res_hi;
                r_plo  <= w_res_lo;
                r_cnt  <= w_cnt_load;
                r_nc   <= w_div_zero;
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                // A zero-divisor divide runs full length but leaves HI/LO alone
                if (!r_nc) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end else if (r_state == MDS_RUN) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_mthi) begin
                r_hi <= dh;
            end
            if (w_mtlo) begin
                r_lo <= dh;
            end
        end
    end

    // Stall already in the start cycle so a back-to-back md/mfhi in D waits
    assign stall      = d_uses_md & (r_busy | w_start);
    assign busy       = r_busy;
    assign done       = r_done;
    assign op_dropped = r_drop;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule : md_seq
`default_nettype wire

// File: tb/tb_md_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_seq
// Description : Self-checking bench for md_seq. A driver issues directed and
//               random md ops and advances a behavioural model; per-cycle
//               expectations and commit results go into queues that an
//               independent monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_seq;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  op = 4'd0;
    logic        valid = 1'b0;
    logic [31:0] dh = 32'd0;
    logic [31:0] dl = 32'd0;
    logic        d_uses_md = 1'b0;
    logic        busy, stall, done, op_dropped;
    logic [31:0] hi, lo;

    md_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .valid      (valid),
        .dh         (dh),
        .dl         (dl),
        .d_uses_md  (d_uses_md),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .op_dropped (op_dropped),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        stall;
        logic        done;
        logic        drop;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        cyc_q[$];
    logic [63:0] done_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: remaining-cycle count rather than a counter encoding
    bit          m_run  = 0;
    int          m_left = 0;
    bit          m_nc   = 0;
    bit          m_done = 0;
    bit          m_drop = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        longint      sq, sr;
        logic [63:0] t;
        if (r) begin
            m_run = 0; m_left = 0; m_nc = 0; m_done = 0; m_drop = 0;
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
            return;
        end
        m_done = 0;
        m_drop = 0;
        if (m_run) begin
            if (v && o >= 1 && o <= 6) m_drop = 1;
            m_left--;
            if (m_left == 0) begin
                m_run  = 0;
                m_done = 1;
                if (!m_nc) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
                done_q.push_back({m_hi, m_lo});
            end
        end else if (v) begin
            case (o)
                4'd1: begin
                    sq = longint'($signed(a)) * longint'($signed(b));
                    t = sq;
                    m_phi = t[63:32]; m_plo = t[31:0]; m_nc = 0;
                    m_run = 1; m_left = MULT_N;
                end
                4'd2: begin
                    t = {32'd0, a} * {32'd0, b};
                    m_phi = t[63:32]; m_plo = t[31:0]; m_nc = 0;
                    m_run = 1; m_left = MULT_N;
                end
                4'd3: begin
                    m_nc = (b == 0);
                    if (!m_nc) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                        t = sq; m_plo = t[31:0];
                        t = sr; m_phi = t[31:0];
                    end
                    m_run = 1; m_left = DIV_N;
                end
                4'd4: begin
                    m_nc = (b == 0);
                    if (!m_nc) begin
                        m_plo = a / b;
                        m_phi = a % b;
                    end
                    m_run = 1; m_left = DIV_N;
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // Apply one cycle of inputs, record what the DUT should show this cycle,
    // then advance the model across the upcoming edge.
    task automatic drive(input bit r, input bit v, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b, input bit du);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; valid = v; op = o; dh = a; dl = b; d_uses_md = du;
        e.busy  = m_run;
        e.done  = m_done;
        e.drop  = m_drop;
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.stall = du && (m_run || (v && o >= 1 && o <= 4));
        cyc_q.push_back(e);
        model_step(r, v, o, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: per-cycle control/HI/LO check plus commit check on done
    initial begin
        exp_t        e;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("busy", {31'd0, busy}, {31'd0, e.busy});
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                chk("done", {31'd0, done}, {31'd0, e.done});
                chk("op_dropped", {31'd0, op_dropped}, {31'd0, e.drop});
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL commit: done pulse with no expected commit at %0t", $time);
                end else begin
                    d = done_q.pop_front();
                    chk("commit_hi", hi, d[63:32]);
                    chk("commit_lo", lo, d[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        // reset
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // MULT / MULTU of 0xFFFFFFFF by 2
        drive(0, 1, 4'd1, 32'hFFFFFFFF, 32'd2, 1);
        idle(7);
        drive(0, 1, 4'd2, 32'hFFFFFFFF, 32'd2, 1);
        idle(7);
        // DIV -7/2, DIVU 7/2
        drive(0, 1, 4'd3, 32'hFFFFFFF9, 32'd2, 1);
        idle(12);
        drive(0, 1, 4'd4, 32'd7, 32'd2, 0);
        idle(12);
        // MTHI then divide by zero
        drive(0, 1, 4'd5, 32'h12345678, 32'd0, 0);
        drive(0, 1, 4'd4, 32'h55, 32'd0, 1);
        idle(12);
        // MTLO dropped while a MULT runs
        drive(0, 1, 4'd1, 32'd3, 32'd4, 0);
        idle(1);
        drive(0, 1, 4'd6, 32'hDEADBEEF, 32'd0, 1);
        idle(6);
        // DIV overflow case
        drive(0, 1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
        idle(12);
        // reset in 4th busy cycle of a DIV
        drive(0, 1, 4'd3, 32'd100, 32'd7, 0);
        idle(3);
        drive(1, 0, 0, 0, 0, 1);
        idle(12);
        // new MULT issued in the done cycle
        drive(0, 1, 4'd1, 32'd5, 32'd6, 0);
        for (int i = 0; i < 20 && !m_done; i++) idle(1);
        drive(0, 1, 4'd1, 32'hFFFF0000, 32'h00010001, 1);
        idle(7);
        // random phase
        for (int i = 0; i < 400; i++) begin
            ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ro = 4'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 30) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ro, ra, rb,
                  1'($urandom_range(0, 1)));
        end
        idle(14);
        @(negedge clk);
        #1;
        chk("cyc_q_drained", cyc_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_md_seq
`default_nettype wire

// File: doc/md_seq.md
Name: md_seq

Overview:
- Sequencer for the E-stage multiply/divide resource.
- Accepts an md op from the E pipeline register, captures the operands and computes the result through a combinational arithmetic sub-module.
- Holds the result for a fixed multi-cycle latency, then commits it to the architectural HI/LO registers.
- Generates busy/stall for the hazard control, so D-stage md instructions and mfhi/mflo wait until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  4  E-stage md opcode (shared header encoding)
- valid  in  1  E-stage instruction is real, i.e. not a bubble or flushed slot
- dh  in  32  operand rs (dividend / multiplicand, or HI/LO write data)
- dl  in  32  operand rt (divisor / multiplier)
- d_uses_md  in  1  D-stage instruction is a mult/div/mthi/mtlo/mfhi/mflo
- busy  out  1  registered; sequence in progress
- stall  out  1  combinational; freeze PC and D, bubble E
- done  out  1  registered; one-cycle pulse when HI/LO commit
- op_dropped  out  1  registered; one-cycle pulse when an op is ignored because busy
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Opcodes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Codes 7..15 are treated as NONE.
- States: IDLE, RUN. A 4-bit down-counter cnt, pending registers p_hi/p_lo, and a no-commit flag nc.
- start = valid & (op in 1..4) & state==IDLE.
- IDLE + start at edge k:
  - p_hi/p_lo <= arithmetic result of dh, dl.
  - cnt <= N-1, with N = MULT_CYCLES or DIV_CYCLES.
  - nc <= (op is DIV/DIVU) & dl==0.
  - state <= RUN, busy <= 1.
- RUN:
  - cnt decrements each edge.
  - At the edge where cnt==0: state <= IDLE, busy <= 0, done <= 1 for one cycle. If nc==0, hi/lo <= p_hi/p_lo.
  - Net effect: busy is high for exactly N cycles. New HI/LO are visible in the cycle after the last busy cycle (edge k+N).
- IDLE + valid + MTHI: hi <= dh at the next edge. MTLO: lo <= dh. Single cycle, busy stays 0, done stays 0.
- Valid op 1..6 arriving while RUN: ignored, op_dropped pulses 1 cycle, sequence unaffected. The control stall is designed to prevent this case.
- stall = d_uses_md & (busy | start). It is asserted in the start cycle itself, so a back-to-back md or mfhi in D waits.
- Arithmetic:
  - MULT: signed 32x32 -> 64. MULTU: unsigned. hi = [63:32], lo = [31:0].
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero: full DIV_CYCLES latency, done pulses, hi/lo unchanged.
- rst (sync, overrides all):
  - state IDLE, cnt 0, busy 0, done 0, op_dropped 0, nc 0, hi 0, lo 0, p_hi/p_lo 0.
  - Reset mid-RUN abandons the op with no commit.
- A new start is accepted in the same cycle done=1, since the state is IDLE then.
- valid=0 with any op: no effect.

Decomposition:
- Shared header md_defs.h holds:
  - op codes MD_NONE..MD_MTLO
  - state encodings MDS_IDLE/MDS_RUN
  - default latencies
- Sub-module md_arith, purely combinational: (op, dh, dl) -> (res_hi, res_lo, div_zero). Instantiated once in md_seq.

Test Plan:
1. MULT dh=0xFFFFFFFF dl=0x2 at edge k -> busy=1 for 5 cycles; stall tracks d_uses_md; at edge k+5 hi=0xFFFFFFFF, lo=0xFFFFFFFE, done one cycle.
2. MULTU dh=0xFFFFFFFF dl=0x2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
3. DIV dh=0xFFFFFFF9 (-7) dl=0x2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
4. MTHI dh=0x12345678 then DIVU dl=0 -> hi=0x12345678 next cycle; divide takes 10 busy cycles, done pulses, hi/lo unchanged.
5. MULT started, MTLO valid at cycle 2 of RUN -> op_dropped pulse, lo not written, MULT result commits on schedule.
6. DIV started, rst=1 in 4th busy cycle -> next cycle busy=0, hi=lo=0, no done. Separately, a new MULT in the done cycle starts immediately.
